// File: rtl/bb_slice_feeder.sv
// Bit-blade slice feeder: serialises an 8-bit act/wgt vector pair into 2-bit slice-pair beats.
// Optional zero-slice skipping is enabled with `define BB_SKIP_ZERO_EN.
module bb_slice_feeder #(
  parameter int LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   act,
  input  logic [8*LANES-1:0]   wgt,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*LANES-1:0]   in1,
  output logic [2*LANES-1:0]   in2,
  output logic [2:0]           shift,
  output logic                 first,
  output logic                 last,
  output logic                 busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [8*LANES-1:0]   act_q, act_d, wgt_q, wgt_d;
  logic [3:0]           k_q, k_d;
  logic [2:0]           shift_q, shift_d;
  logic                 first_q, first_d, last_q, last_d;
  logic                 out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
  logic                 go_idle;

  function automatic logic [2:0] pair_shift(input logic [3:0] k);
    return {1'b0, k[3:2]} + {1'b0, k[1:0]};
  endfunction

`ifdef BB_SKIP_ZERO_EN
  logic [15:0] mask_q, mask_d;
  logic        zero_q, zero_d;
  logic [4:0]  nxt_k, aft_k;

  // Bit k=4i+j set when act slice i and wgt slice j are both nonzero in some lane.
  function automatic logic [15:0] pair_mask(input logic [8*LANES-1:0] a, input logic [8*LANES-1:0] w);
    logic [3:0]  anz;
    logic [3:0]  wnz;
    logic [15:0] m;
    anz = '0;
    wnz = '0;
    for (int s = 0; s < 4; s++) begin
      for (int e = 0; e < LANES; e++) begin
        anz[s] = anz[s] | (|a[8*e+2*s +: 2]);
        wnz[s] = wnz[s] | (|w[8*e+2*s +: 2]);
      end
    end
    for (int p = 0; p < 16; p++) m[p] = anz[p/4] & wnz[p%4];
    return m;
  endfunction

  // Lowest set bit at or above 'from'; 16 when none remain.
  function automatic logic [4:0] next_pair(input logic [15:0] m, input logic [4:0] from);
    logic [4:0] r;
    r = 5'd16;
    for (int b = 15; b >= 0; b--) begin
      if (m[b] && (5'(b) >= from)) r = 5'(b);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    wgt_d       = wgt_q;
    k_d         = k_q;
    shift_d     = shift_q;
    first_d     = first_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
`ifdef BB_SKIP_ZERO_EN
    mask_d      = mask_q;
    zero_d      = zero_q;
    nxt_k       = 5'd0;
    aft_k       = 5'd0;
`endif
    // Flush outranks both capture and beat advance.
    go_idle = flush | ((state_q == RUN) & out_ready & last_q);

    if (go_idle) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      busy_d      = 1'b0;
      first_d     = 1'b0;
      last_d      = 1'b0;
      k_d         = 4'd0;
      shift_d     = 3'd0;
`ifdef BB_SKIP_ZERO_EN
      zero_d      = 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        state_d     = RUN;
        act_d       = act;
        wgt_d       = wgt;
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
        busy_d      = 1'b1;
        first_d     = 1'b1;
`ifdef BB_SKIP_ZERO_EN
        mask_d  = pair_mask(act, wgt);
        nxt_k   = next_pair(mask_d, 5'd0);
        aft_k   = next_pair(mask_d, nxt_k + 5'd1);
        zero_d  = nxt_k[4];
        k_d     = nxt_k[4] ? 4'd0 : nxt_k[3:0];
        last_d  = aft_k[4];
`else
        k_d     = 4'd0;
        last_d  = 1'b0;
`endif
        shift_d = pair_shift(k_d);
      end
    end else if (out_ready) begin
      first_d = 1'b0;
`ifdef BB_SKIP_ZERO_EN
      nxt_k  = next_pair(mask_q, {1'b0, k_q} + 5'd1);
      aft_k  = next_pair(mask_q, nxt_k + 5'd1);
      k_d    = nxt_k[3:0];
      last_d = aft_k[4];
`else
      k_d    = k_q + 4'd1;
      last_d = (k_q == 4'd14);
`endif
      shift_d = pair_shift(k_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_q       <= '0;
      wgt_q       <= '0;
      k_q         <= 4'd0;
      shift_q     <= 3'd0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef BB_SKIP_ZERO_EN
      mask_q      <= '0;
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      k_q         <= k_d;
      shift_q     <= shift_d;
      first_q     <= first_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef BB_SKIP_ZERO_EN
      mask_q      <= mask_d;
      zero_q      <= zero_d;
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] a_byte, w_byte;
      assign a_byte = act_q[8*gi +: 8];
      assign w_byte = wgt_q[8*gi +: 8];
`ifdef BB_SKIP_ZERO_EN
      assign in1[2*gi +: 2] = zero_q ? 2'b00 : a_byte[{k_q[3:2], 1'b0} +: 2];
      assign in2[2*gi +: 2] = zero_q ? 2'b00 : w_byte[{k_q[1:0], 1'b0} +: 2];
`else
      assign in1[2*gi +: 2] = a_byte[{k_q[3:2], 1'b0} +: 2];
      assign in2[2*gi +: 2] = w_byte[{k_q[1:0], 1'b0} +: 2];
`endif
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign shift     = shift_q;
  assign first     = first_q;
  assign last      = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bb_slice_feeder.sv
// Self-checking bench for bb_slice_feeder: directed scenarios plus randomized vector pairs
// compared against a slice-level reference model and a dot-product identity.
module tb_bb_slice_feeder;
  localparam int LANES = 16;

  logic         clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [127:0] act, wgt;
  logic [31:0]  in1, in2;
  logic [2:0]   shift;
  logic         first, last, busy;

  int tests = 0;
  int fails = 0;
  int txn_no = 0;

  typedef struct packed {
    logic [31:0] b1;
    logic [31:0] b2;
    logic [2:0]  sh;
    logic        f;
    logic        l;
  } beat_t;

  beat_t exp_q[$];

  bb_slice_feeder #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wgt(wgt), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .in1(in1), .in2(in2), .shift(shift),
    .first(first), .last(last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: enumerate slice pairs i-outer/j-inner, optionally dropping pairs with an all-zero slice.
  task automatic build_model(input logic [127:0] a, input logic [127:0] w);
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = '0;
        for (int e = 0; e < LANES; e++) begin
          b.b1[2*e +: 2] = 2'((a >> (8*e + 2*i)) & 128'd3);
          b.b2[2*e +: 2] = 2'((w >> (8*e + 2*j)) & 128'd3);
        end
        b.sh = 3'(i + j);
`ifdef BB_SKIP_ZERO_EN
        if (b.b1 != 0 && b.b2 != 0) exp_q.push_back(b);
`else
        exp_q.push_back(b);
`endif
      end
    end
    if (exp_q.size() == 0) begin
      b = '0;
      exp_q.push_back(b);
    end
    exp_q[0].f = 1'b1;
    exp_q[exp_q.size()-1].l = 1'b1;
  endtask

  function automatic longint pe(input logic [31:0] x, input logic [31:0] y);
    longint s = 0;
    for (int e = 0; e < LANES; e++) s += longint'(x[2*e +: 2]) * longint'(y[2*e +: 2]);
    return s;
  endfunction

  function automatic longint dot(input logic [127:0] a, input logic [127:0] w);
    longint s = 0;
    for (int e = 0; e < LANES; e++) s += longint'(a[8*e +: 8]) * longint'(w[8*e +: 8]);
    return s;
  endfunction

  function automatic logic [127:0] rand_vec(input logic [3:0] keep);
    logic [127:0] v;
    logic [7:0]   m;
    m = {{2{keep[3]}}, {2{keep[2]}}, {2{keep[1]}}, {2{keep[0]}}};
    for (int e = 0; e < LANES; e++) v[8*e +: 8] = 8'($urandom) & m;
    return v;
  endfunction

  // mode 0: out_ready held high; 1: random out_ready; 2: 3-cycle stall on beat 5.
  task automatic run_txn(input logic [127:0] a, input logic [127:0] w, input int mode,
                         output int nb, output longint sum);
    beat_t cur, held_v, e;
    bit    held, done, r;
    int    stall, nexp;
    build_model(a, w);
    nexp = exp_q.size();
    check("idle_in_ready", in_ready, 1);
    act = a; wgt = w; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    act = {$urandom, $urandom, $urandom, $urandom};
    wgt = {$urandom, $urandom, $urandom, $urandom};
    held = 0; done = 0; stall = 0; nb = 0; sum = 0;
    held_v = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      check("run_out_valid", out_valid, 1);
      check("run_in_ready", in_ready, 0);
      check("run_busy", busy, 1);
      cur = {in1, in2, shift, first, last};
      if (held) check("hold_stable", cur, held_v);
      case (mode)
        0:       r = 1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: begin
          if (nb == 5 && stall < 3) begin r = 0; stall++; end
          else r = 1;
        end
      endcase
      out_ready = r;
      if (r) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        sum += pe(in1, in2) << (2 * shift);
        nb++;
        held = 0;
        if (last) done = 1;
      end else begin
        held = 1;
        held_v = cur;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    if (!done) check("timeout_last", 0, 1);
    check("beat_count", nb, nexp);
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_busy", busy, 0);
    txn_no++;
    $display("[TB] txn %0d mode=%0d beats=%0d weighted_sum=%0d", txn_no, mode, nb, sum);
  endtask

  task automatic start_accept(input logic [127:0] a, input logic [127:0] w, input int n);
    act = a; wgt = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    out_ready = 1'b0;
  endtask

  logic [127:0] ff_v, one_v, a_v, w_v;
  int           nb;
  longint       sum;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    act = '0; wgt = '0;
    ff_v = {16{8'hFF}};
    one_v = {16{8'h01}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in1", in1, 0);
    check("rst_in2", in2, 0);
    check("rst_shift", shift, 0);
    check("rst_first_last", {first, last}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full sequence: weighted PE sum reconstructs the dot product 16*255*1.
    run_txn(ff_v, one_v, 0, nb, sum);
    check("full_sum", sum, 4080);
`ifdef BB_SKIP_ZERO_EN
    check("full_beats", nb, 4);
`else
    check("full_beats", nb, 16);
`endif

    run_txn(ff_v, ff_v, 2, nb, sum);
    check("bp_sum", sum, dot(ff_v, ff_v));

    // Reset in the middle of a transaction.
    start_accept(ff_v, ff_v, 7);
    check("pre_rst_shift_k7", shift, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(ff_v, ff_v, 0, nb, sum);

    // Flush at k=9 with out_ready low.
    start_accept(ff_v, ff_v, 9);
    check("pre_flush_shift_k9", shift, 3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_busy", busy, 0);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("flush_no_beats", out_valid, 0);
    end
    out_ready = 1'b0;

    // Flush wins over capture in IDLE.
    act = ff_v; wgt = ff_v; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_capture_busy", busy, 0);
    check("flush_capture_in_ready", in_ready, 1);

    // Skip case and all-zero case.
    run_txn({16{8'h03}}, {16{8'hC0}}, 0, nb, sum);
`ifdef BB_SKIP_ZERO_EN
    check("skip_beats", nb, 1);
`else
    check("skip_beats", nb, 16);
`endif
    run_txn('0, rand_vec(4'hF), 1, nb, sum);
    check("zero_sum", sum, 0);

    // Randomized pairs with randomly cleared slices and random backpressure.
    for (int t = 0; t < 20; t++) begin
      a_v = rand_vec(4'($urandom));
      w_v = rand_vec(4'($urandom));
      run_txn(a_v, w_v, 1, nb, sum);
      check("rand_sum", sum, dot(a_v, w_v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
